// File: rtl/iteration_m_bw16.sv
// iteration_m_bw16: iterates x(k+1) = child(x(k), IN1) for CNT steps, starting
// from x(0) = IN0. The block drives a child operation through a level
// start/ready handshake and reports x(N) on RES with RD high.
module iteration_m_bw16 #(
  parameter int BW = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ST,
  output logic          RD,
  output logic [BW-1:0] RES,
  input  logic [BW-1:0] IN0,
  input  logic [BW-1:0] IN1,
  input  logic [BW-1:0] CNT,
  output logic          C_ST,
  input  logic          C_RD,
  input  logic [BW-1:0] C_RES,
  output logic [BW-1:0] C_IN0,
  output logic [BW-1:0] C_IN1
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CALL    = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t        state;
  logic [BW-1:0] x_q;
  logic [BW-1:0] arg_q;
  logic [BW-1:0] cnt_q;
  // Set when the caller drops ST mid-request; the child is then drained and
  // the request is discarded without ever raising RD.
  logic          abort_q;

  // The working value doubles as the result and as the child's first
  // argument, so RES holds its last value in IDLE and clears with reset.
  assign RES   = x_q;
  assign C_IN0 = x_q;
  assign C_IN1 = arg_q;

  // Control FSM: latches the request, sequences child calls, handles abort.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      RD      <= 1'b0;
      C_ST    <= 1'b0;
      x_q     <= '0;
      arg_q   <= '0;
      cnt_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          RD      <= 1'b0;
          C_ST    <= 1'b0;
          abort_q <= 1'b0;
          // A child still reporting ready (e.g. after a reset mid-call) must
          // be seen low before a new request is started.
          if (ST && !C_RD) begin
            x_q   <= IN0;
            arg_q <= IN1;
            cnt_q <= CNT;
            if (CNT == '0) begin
              state <= DONE;
              RD    <= 1'b1;
            end else begin
              state <= CALL;
              C_ST  <= 1'b1;
            end
          end
        end
        CALL: begin
          if (!ST) begin
            C_ST    <= 1'b0;
            abort_q <= 1'b1;
            state   <= RELEASE;
          end else if (C_RD) begin
            x_q   <= C_RES;
            cnt_q <= cnt_q - BW'(1);
            C_ST  <= 1'b0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          // Only leave once the child has dropped ready, so C_ST is never
          // re-raised while C_RD is still high.
          if (!C_RD) begin
            if (abort_q || !ST) begin
              abort_q <= 1'b0;
              state   <= IDLE;
            end else if (cnt_q == '0) begin
              RD    <= 1'b1;
              state <= DONE;
            end else begin
              C_ST  <= 1'b1;
              state <= CALL;
            end
          end
        end
        DONE: begin
          if (!ST) begin
            RD    <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
